strobe_writer: RTL

//  Sync-domain initiator for the async-style latch interface (d, c, s, r) that

---
 rtl/strobe_writer_if.sv | 25 ++
 rtl/strobe_writer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/strobe_writer_if.sv
// Request/status and register-bank lines between a bus-decode initiator and strobe_writer.
// The master side issues requests; the slave side sequences d/c/s/r onto the register bank.
interface strobe_writer_if #(
  parameter int WIDTH = 8
);
  logic             wr_req;
  logic [1:0]       wr_cmd;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d_out;
  logic             c_out;
  logic             s_out;
  logic             r_out;

  modport master (
    output wr_req, wr_cmd, wr_data,
    input  busy, done, d_out, c_out, s_out, r_out
  );

  modport slave (
    input  wr_req, wr_cmd, wr_data,
    output busy, done, d_out, c_out, s_out, r_out
  );
endinterface

// File: rtl/strobe_writer.sv
// Turns a one-cycle write/set/reset request into data setup, a fixed-width strobe and data hold.
// All outputs are registered on posedge so negedge-sampling register models see half a cycle of margin.
module strobe_writer #(
  parameter int WIDTH = 8,
  parameter int SETUP = 1,
  parameter int PULSE = 2,
  parameter int HOLD  = 1
) (
  input  logic clock,
  input  logic resb,
  strobe_writer_if.slave bus
);

  localparam int PULSE_E = (PULSE < 1) ? 1 : PULSE;
  localparam int MAX_A   = (SETUP > PULSE_E) ? SETUP : PULSE_E;
  localparam int MAX_V   = (MAX_A > HOLD) ? MAX_A : HOLD;
  localparam int CW      = (MAX_V < 2) ? 1 : $clog2(MAX_V + 1);

  localparam logic [CW-1:0] SETUP_C = CW'(SETUP);
  localparam logic [CW-1:0] PULSE_C = CW'(PULSE_E);
  localparam logic [CW-1:0] HOLD_C  = CW'(HOLD);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam bit HAS_SETUP = (SETUP > 0);
  localparam bit HAS_HOLD  = (HOLD > 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_STROBE = 2'b10,
    ST_HOLD   = 2'b11
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [1:0]       cmd_r, cmd_s;
  logic [WIDTH-1:0] d_out_r, d_s;
  logic             c_out_r, c_s;
  logic             s_out_r, s_s;
  logic             r_out_r, r_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  // Next state, counter reload/countdown, and next value of every registered output.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    cmd_s   = cmd_r;
    d_s     = d_out_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.wr_req) begin
          cmd_s = bus.wr_cmd;
          d_s   = bus.wr_data;
          if (HAS_SETUP) begin
            state_s = ST_SETUP;
            cnt_s   = SETUP_C;
          end else begin
            state_s = ST_STROBE;
            cnt_s   = PULSE_C;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r <= ONE_C) begin
          state_s = ST_STROBE;
          cnt_s   = PULSE_C;
        end else begin
          cnt_s = cnt_r - ONE_C;
        end
      end
      ST_STROBE: begin
        if (cnt_r <= ONE_C) begin
          if (HAS_HOLD) begin
            state_s = ST_HOLD;
            cnt_s   = HOLD_C;
          end else begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end
        end else begin
          cnt_s = cnt_r - ONE_C;
        end
      end
      ST_HOLD: begin
        if (cnt_r <= ONE_C) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          cnt_s = cnt_r - ONE_C;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = ONE_C;
      end
    endcase
    // Command 11 keeps the sequence timing but raises no strobe.
    c_s    = (state_s == ST_STROBE) && (cmd_s == 2'b00);
    s_s    = (state_s == ST_STROBE) && (cmd_s == 2'b01);
    r_s    = (state_s == ST_STROBE) && (cmd_s == 2'b10);
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers; synchronous reset aborts any sequence without a done pulse.
  always_ff @(posedge clock) begin
    if (!resb) begin
      state_r <= ST_IDLE;
      cnt_r   <= ONE_C;
      cmd_r   <= 2'b00;
      d_out_r <= {WIDTH{1'b0}};
      c_out_r <= 1'b0;
      s_out_r <= 1'b0;
      r_out_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      cmd_r   <= cmd_s;
      d_out_r <= d_s;
      c_out_r <= c_s;
      s_out_r <= s_s;
      r_out_r <= r_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.d_out = d_out_r;
  assign bus.c_out = c_out_r;
  assign bus.s_out = s_out_r;
  assign bus.r_out = r_out_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

endmodule
